// File: rtl/tnoc_pkg.sv
// tnoc_pkg: shared flit field positions, count sizing and packet state type
package tnoc_pkg;
    localparam int TAIL_FROM_MSB = 0;
    localparam int HEAD_FROM_MSB = 1;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic {IDLE, IN_PACKET} pkt_state_t;
endpackage

// File: rtl/tnoc_vc_fifo.sv
// tnoc_vc_fifo: single-VC flit FIFO with occupancy and registered vc_available
module tnoc_vc_fifo import tnoc_pkg::*; #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int THRESHOLD = 2,
    parameter int CW = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [FLIT_WIDTH-1:0] flit_in,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  valid,
    output logic                  full,
    output logic                  vc_available,
    output logic [CW-1:0]         count
);
    localparam int PW = $clog2(DEPTH);
    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_next;
    assign count_next = count + CW'(push) - CW'(pop);
    assign valid = count != '0;
    assign full = count == CW'(DEPTH);
    assign flit_out = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            vc_available <= 1'b1;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count_next;
            vc_available <= (CW'(DEPTH) - count_next) >= CW'(THRESHOLD);
        end
    end
    // storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= flit_in;
    end
endmodule

// File: rtl/tnoc_input_vc_buffer.sv
// tnoc_input_vc_buffer: per-VC input flit buffering with lowest-VC-wins ready masking
module tnoc_input_vc_buffer import tnoc_pkg::*; #(
    parameter int VCS = 2,
    parameter int FLIT_WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int THRESHOLD = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [VCS-1:0]                      i_valid,
    output logic [VCS-1:0]                      o_ready,
    input  logic [FLIT_WIDTH-1:0]               i_flit,
    output logic [VCS-1:0]                      o_vc_available,
    output logic [VCS-1:0]                      o_valid,
    input  logic [VCS-1:0]                      i_ready,
    output logic [VCS*FLIT_WIDTH-1:0]           o_flit,
    output logic [VCS*count_width(DEPTH)-1:0]   o_occupancy
);
    localparam int CW = count_width(DEPTH);
    logic [VCS-1:0] full, push, pop, lower;
    logic head, tail;
    pkt_state_t state [VCS];
    // lower[v] is set when any VC below v is requesting
    assign lower = ~(i_valid ^ (i_valid - VCS'(1)));
    assign o_ready = ~full & ~lower;
    assign push = i_valid & o_ready;
    assign pop = o_valid & i_ready;
    assign head = i_flit[FLIT_WIDTH-1-HEAD_FROM_MSB];
    assign tail = i_flit[FLIT_WIDTH-1-TAIL_FROM_MSB];
    for (genvar v = 0; v < VCS; v++) begin : g_vc
        tnoc_vc_fifo #(
            .FLIT_WIDTH(FLIT_WIDTH),
            .DEPTH(DEPTH),
            .THRESHOLD(THRESHOLD),
            .CW(CW)
        ) u_fifo (
            .clk(i_clk),
            .rst_n(i_rst_n),
            .push(push[v]),
            .pop(pop[v]),
            .flit_in(i_flit),
            .flit_out(o_flit[v*FLIT_WIDTH +: FLIT_WIDTH]),
            .valid(o_valid[v]),
            .full(full[v]),
            .vc_available(o_vc_available[v]),
            .count(o_occupancy[v*CW +: CW])
        );
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int v = 0; v < VCS; v++) state[v] <= IDLE;
        end else begin
            for (int v = 0; v < VCS; v++)
                if (push[v]) state[v] <= tail ? IDLE : head ? IN_PACKET : state[v];
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert ($onehot0(i_valid)) else $error("multiple i_valid bits set: %b", i_valid);
            for (int v = 0; v < VCS; v++)
                if (push[v]) begin
                    assert (state[v] == IN_PACKET || head) else $error("vc%0d non-head flit while idle", v);
                    assert (state[v] == IDLE || !head) else $error("vc%0d head flit inside packet", v);
                end
        end
    end
endmodule

// File: tb/tb_tnoc_input_vc_buffer.sv
// tb_tnoc_input_vc_buffer: directed stimulus with per-VC scoreboard queues and a pop monitor
module tb_tnoc_input_vc_buffer;
    localparam int VCS = 2, FW = 64, DEPTH = 4, THR = 2, CW = 3;
    logic clk = 0;
    logic rst_n = 0;
    logic [VCS-1:0] i_valid = '0, i_ready = '0;
    logic [FW-1:0] i_flit = '0;
    logic [VCS-1:0] o_ready, o_vc_available, o_valid;
    logic [VCS*FW-1:0] o_flit;
    logic [VCS*CW-1:0] o_occupancy;
    logic [FW-1:0] exp_q [VCS][$];
    int checks = 0, errors = 0;

    tnoc_input_vc_buffer #(.VCS(VCS), .FLIT_WIDTH(FW), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flit(i_flit),
        .o_vc_available(o_vc_available), .o_valid(o_valid), .i_ready(i_ready),
        .o_flit(o_flit), .o_occupancy(o_occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic h, input logic t, input int d);
        return {t, h, 62'(d)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input int v, input logic [FW-1:0] f, input logic expect_accept);
        i_valid = VCS'(1) << v;
        i_flit = f;
        if (expect_accept) exp_q[v].push_back(f);
    endtask

    // pop monitor: the pop for the next edge is visible on the falling edge
    initial forever begin
        @(negedge clk);
        for (int v = 0; v < VCS; v++)
            if (o_valid[v] && i_ready[v]) begin
                checks++;
                if (exp_q[v].size() == 0) begin
                    errors++;
                    $display("FAIL pop_vc%0d unexpected flit %h", v, o_flit[v*FW +: FW]);
                end else begin
                    logic [FW-1:0] e;
                    e = exp_q[v].pop_front();
                    if (o_flit[v*FW +: FW] !== e) begin
                        errors++;
                        $display("FAIL pop_vc%0d got %h want %h", v, o_flit[v*FW +: FW], e);
                    end
                end
            end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("reset_valid", 64'(o_valid), 64'b00);
        chk("reset_ready", 64'(o_ready), 64'b11);
        chk("reset_avail", 64'(o_vc_available), 64'b11);
        chk("reset_occ", 64'(o_occupancy), 64'd0);
        rst_n = 1;
        tick();
        // single head+tail flit on VC0
        push_flit(0, mk(1, 1, 'hA5), 1);
        tick();
        i_valid = '0;
        chk("single_valid", 64'(o_valid), 64'b01);
        chk("single_occ1", 64'(o_occupancy[2:0]), 64'd1);
        i_ready = 2'b01;
        tick();
        i_ready = '0;
        chk("single_occ0", 64'(o_occupancy[2:0]), 64'd0);
        chk("single_empty", 64'(o_valid), 64'b00);
        // fill VC1 with a 4-flit packet, no pops
        for (int k = 0; k < 4; k++) begin
            push_flit(1, mk(k == 0, k == 3, 16 + k), 1);
            tick();
            chk($sformatf("fill_avail_%0d", k), 64'(o_vc_available[1]), 64'((4 - (k + 1)) >= 2));
            chk($sformatf("fill_ready_%0d", k), 64'(o_ready[1]), 64'(k < 3));
        end
        chk("fill_vc0_ready", 64'(o_ready[0]), 64'd1);
        chk("fill_occ", 64'(o_occupancy[5:3]), 64'd4);
        // full VC1: push is refused while the pop proceeds
        push_flit(1, mk(1, 0, 'h99), 0);
        i_ready = 2'b10;
        tick();
        i_valid = '0;
        i_ready = '0;
        chk("fullpp_occ", 64'(o_occupancy[5:3]), 64'd3);
        chk("fullpp_ready", 64'(o_ready[1]), 64'd1);
        chk("fullpp_avail", 64'(o_vc_available[1]), 64'd0);
        i_ready = 2'b10;
        repeat (3) tick();
        i_ready = '0;
        chk("drain_occ", 64'(o_occupancy[5:3]), 64'd0);
        chk("drain_avail", 64'(o_vc_available[1]), 64'd1);
        // streaming 10 flits through VC0 with steady occupancy
        for (int k = 0; k < 10; k++) begin
            push_flit(0, mk(k == 0, k == 9, k), 1);
            i_ready = (k == 0) ? 2'b00 : 2'b01;
            tick();
            chk($sformatf("stream_occ_%0d", k), 64'(o_occupancy[2:0]), 64'd1);
        end
        i_valid = '0;
        i_ready = 2'b01;
        tick();
        i_ready = '0;
        chk("stream_occ_end", 64'(o_occupancy[2:0]), 64'd0);
        // ready masking between edges: VC0 wins
        i_valid = 2'b11;
        #1;
        chk("mask_ready", 64'(o_ready), 64'b01);
        i_valid = '0;
        tick();
        // async reset in the middle of a packet
        for (int k = 0; k < 3; k++) begin
            push_flit(0, mk(k == 0, 0, 32 + k), 1);
            tick();
        end
        i_valid = '0;
        chk("pre_rst_occ", 64'(o_occupancy[2:0]), 64'd3);
        #2 rst_n = 0;
        #1;
        chk("rst_valid", 64'(o_valid), 64'b00);
        chk("rst_occ", 64'(o_occupancy), 64'd0);
        exp_q[0].delete();
        exp_q[1].delete();
        #2 rst_n = 1;
        tick();
        chk("post_rst_avail", 64'(o_vc_available), 64'b11);
        chk("post_rst_ready", 64'(o_ready), 64'b11);
        // packet state must be idle again
        push_flit(0, mk(1, 1, 'h5A), 1);
        tick();
        i_valid = '0;
        i_ready = 2'b01;
        tick();
        i_ready = '0;
        tick();
        chk("final_q0_empty", 64'(exp_q[0].size()), 64'd0);
        chk("final_q1_empty", 64'(exp_q[1].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
